// File: rtl/twofish_mode_ctrl_pkg.sv
// twofish_pkg: shared types and constants for the Twofish mode controller.
//   BLOCK_W   : cipher block / key width
//   state_e   : sequencing FSM states
//   MODE_*    : chaining mode encodings for mode_cbc
//   DIR_*     : direction encodings for EnDe
//   blk_cfg_t : per-block configuration latched on accept
package twofish_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_PUSH    = 3'd4
  } state_e;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;
  localparam logic DIR_ENC  = 1'b0;
  localparam logic DIR_DEC  = 1'b1;

  typedef struct packed {
    logic cbc;
    logic dec;
  } blk_cfg_t;

  // CBC encrypt is the only case that whitens the core input with the chain.
  function automatic logic pre_xor(input logic cbc, input logic dec);
    return (cbc == MODE_CBC) && (dec == DIR_ENC);
  endfunction

  // CBC decrypt is the only case that whitens the core output with the chain.
  function automatic logic post_xor(input logic cbc, input logic dec);
    return (cbc == MODE_CBC) && (dec == DIR_DEC);
  endfunction

endpackage

// File: rtl/twofish_mode_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk/rst      : clock, asynchronous active-high reset
//   push/wdata   : write strobe and data (ignored when full unless popping)
//   pop/rdata    : read strobe and head-of-queue data (ignored when empty)
//   full/empty   : occupancy flags
//   count        : current number of entries
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wptr_q, wptr_d;
  logic [AW-1:0]               rptr_q, rptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write in the same cycle as a read.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/twofish_mode_ctrl.sv
// twofish_mode_ctrl: ECB/CBC streaming mode controller around the Twofish core.
//   Clk/Reset            : clock, asynchronous active-high reset
//   key                  : cipher key, passed straight through to core_key
//   mode_cbc/EnDe        : per-block mode and direction, sampled on accept
//   iv/iv_load           : chain register load (IDLE only, beats input accept)
//   in_data/valid/ready  : input block stream
//   out_data/valid/ready : output block stream (FIFO head)
//   core_*               : Start/EnDe/block/key -> o/busy handshake to core
//   err                  : sticky core timeout flag
//   blk_count            : completed blocks, wrapping
// One block is in flight at a time; a block is only accepted when a FIFO slot
// is free, so the PUSH state can never find the FIFO full.
module twofish_mode_ctrl #(
  parameter int BLOCK_W    = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [BLOCK_W-1:0] key,
  input  logic               mode_cbc,
  input  logic               EnDe,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] core_block,
  output logic [BLOCK_W-1:0] core_key,
  output logic               core_start,
  output logic               core_ende,
  input  logic [BLOCK_W-1:0] core_o,
  input  logic               core_busy,
  output logic               err,
  output logic [CNT_W-1:0]   blk_count
);

  import twofish_pkg::*;

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);

  state_e             state_q, state_d;
  blk_cfg_t           cfg_q, cfg_d;
  logic [BLOCK_W-1:0] din_q, din_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] core_block_q, core_block_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic [TW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   blk_count_q, blk_count_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FAW:0]       fifo_count;

  // Held low during Reset so the handshake reads idle while reset is applied.
  assign in_ready   = (state_q == ST_IDLE) && !iv_load && !Reset &&
                      (fifo_count < (FAW+1)'(FIFO_DEPTH));
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;
  assign core_key   = key;
  assign core_block = core_block_q;
  assign core_ende  = cfg_q.dec;
  assign core_start = (state_q == ST_START);
  assign err        = err_q;
  assign blk_count  = blk_count_q;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    din_d        = din_q;
    chain_d      = chain_q;
    core_block_d = core_block_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    blk_count_d  = blk_count_q;
    fifo_push    = 1'b0;
    cnt_inc      = cnt_q + TW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (iv_load) begin
          chain_d = iv;
        end else if (in_valid && in_ready) begin
          cfg_d.cbc    = mode_cbc;
          cfg_d.dec    = EnDe;
          din_d        = in_data;
          core_block_d = pre_xor(mode_cbc, EnDe) ? (in_data ^ chain_q) : in_data;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI, ST_WAIT_LO: begin
        cnt_d = cnt_inc;
        // Core progress wins over a timeout landing in the same cycle.
        if (state_q == ST_WAIT_HI && core_busy) begin
          state_d = ST_WAIT_LO;
        end else if (state_q == ST_WAIT_LO && !core_busy) begin
          res_d = post_xor(cfg_q.cbc, cfg_q.dec) ? (core_o ^ chain_q) : core_o;
          if (cfg_q.cbc == MODE_CBC)
            chain_d = (cfg_q.dec == DIR_DEC) ? din_q : core_o;
          state_d = ST_PUSH;
        end else if (cnt_inc == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PUSH: begin
        fifo_push   = !fifo_full;
        blk_count_d = blk_count_q + CNT_W'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      din_q        <= '0;
      chain_q      <= '0;
      core_block_q <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      din_q        <= din_d;
      chain_q      <= chain_d;
      core_block_q <= core_block_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      blk_count_q  <= blk_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (fifo_push),
    .wdata (res_q),
    .pop   (fifo_pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_twofish_mode_ctrl.sv
// Bench for twofish_mode_ctrl with a behavioural core stand-in: an invertible
// keyed permutation (xor + rotate) with a few cycles of busy. Expected results
// are pushed on accept and compared as blocks leave the output FIFO.
module tb_twofish_mode_ctrl;

  localparam int BW    = 128;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = 16;
  localparam logic [BW-1:0] KC = 128'h0123456789abcdeffedcba9876543210;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [BW-1:0] key = '0, iv = '0, in_data = '0;
  logic          mode_cbc = 1'b0, EnDe = 1'b0, iv_load = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, core_start, core_ende, core_busy, err;
  logic [BW-1:0] out_data, core_block, core_key, core_o;
  logic [CW-1:0] blk_count;

  logic          core_dead = 1'b0;
  logic [2:0]    stub_cnt;

  int            n_checks = 0, n_errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] chain_m = '0;
  logic [CW-1:0] bcnt = '0;

  always #5 Clk = ~Clk;

  twofish_mode_ctrl #(
    .BLOCK_W(BW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .key(key), .mode_cbc(mode_cbc), .EnDe(EnDe),
    .iv(iv), .iv_load(iv_load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .core_block(core_block), .core_key(core_key),
    .core_start(core_start), .core_ende(core_ende), .core_o(core_o),
    .core_busy(core_busy), .err(err), .blk_count(blk_count)
  );

  function automatic logic [BW-1:0] f_enc(input logic [BW-1:0] x, input logic [BW-1:0] k);
    logic [BW-1:0] t;
    t = x ^ k ^ KC;
    return {t[BW-14:0], t[BW-1:BW-13]};
  endfunction

  function automatic logic [BW-1:0] f_dec(input logic [BW-1:0] y, input logic [BW-1:0] k);
    return {y[12:0], y[BW-1:13]} ^ k ^ KC;
  endfunction

  // Core stand-in: busy rises the cycle after Start and stays up for 4 cycles.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      core_busy <= 1'b0;
      stub_cnt  <= '0;
      core_o    <= '0;
    end else if (core_start && !core_dead) begin
      core_busy <= 1'b1;
      stub_cnt  <= 3'd3;
      core_o    <= core_ende ? f_dec(core_block, core_key) : f_enc(core_block, core_key);
    end else if (core_busy) begin
      if (stub_cnt == 0) core_busy <= 1'b0;
      else               stub_cnt  <= stub_cnt - 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [BW-1:0] d, input logic cbc, input logic de, input bit exp_out);
    int n = 0;
    logic [BW-1:0] ci, co, r;
    in_data = d; mode_cbc = cbc; EnDe = de; in_valid = 1'b1;
    @(negedge Clk);
    while (!in_ready && n < 300) begin @(negedge Clk); n++; end
    chk("accept_wait", n < 300, 1);
    @(posedge Clk); #1 in_valid = 1'b0;
    if (exp_out) begin
      ci = (cbc && !de) ? d ^ chain_m : d;
      co = de ? f_dec(ci, key) : f_enc(ci, key);
      r  = (cbc && de) ? co ^ chain_m : co;
      if (cbc) chain_m = de ? d : co;
      exp_q.push_back(r);
      bcnt++;
    end
  endtask

  // in_valid is held high too: the load must win and nothing may be accepted.
  task automatic load_iv(input logic [BW-1:0] v);
    iv = v; iv_load = 1'b1; in_valid = 1'b1; in_data = ~v;
    @(negedge Clk);
    chk("ivload_in_ready", in_ready, 0);
    @(posedge Clk); #1 iv_load = 1'b0; in_valid = 1'b0;
    chain_m = v;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin @(posedge Clk); #1; n++; end
    chk("drain_wait", n < 1000, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] c1, c2, d;
    int n;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_err", err, 0);
    chk("rst_blk_count", blk_count, 0);
    @(posedge Clk); #1 Reset = 1'b0;

    // ECB encrypt of a zero block under a zero key
    send('0, 1'b0, 1'b0, 1);
    drain();
    chk("ecb_blk_count", blk_count, 1);
    chk("ecb_err", err, 0);

    // CBC encrypt two zero blocks, then decrypt them back to zero
    load_iv('0);
    send('0, 1'b1, 1'b0, 1);
    send('0, 1'b1, 1'b0, 1);
    drain();
    c1 = f_enc('0, '0);
    c2 = f_enc(c1, '0);
    load_iv('0);
    send(c1, 1'b1, 1'b1, 1);
    send(c2, 1'b1, 1'b1, 1);
    drain();
    // The chain should now hold c2: a further CBC encrypt depends on it
    send('0, 1'b1, 1'b0, 1);
    drain();
    chk("cbc_blk_count", blk_count, bcnt);

    // Mixed modes and directions, nonzero key, random output backpressure
    key = {$urandom, $urandom, $urandom, $urandom};
    chk("core_key", core_key, key);
    load_iv({$urandom, $urandom, $urandom, $urandom});
    fork
      for (int i = 0; i < 10; i++)
        send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1);
      begin
        repeat (80) begin @(posedge Clk); #1 out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    chk("mix_blk_count", blk_count, bcnt);

    // FIFO fill: four blocks with the output stalled, then in_ready must drop
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1);
    repeat (20) @(negedge Clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_blk_count", blk_count, bcnt);
    @(posedge Clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 2; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1);
    drain();
    chk("fill_blk_count", blk_count, bcnt);

    // Timeout: core never raises busy
    core_dead = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0, 1'b0, 0);
    @(negedge Clk);
    chk("tmo_core_start", core_start, 1);
    n = 0;
    while (!err && n < 40) begin @(negedge Clk); n++; end
    chk("tmo_cycles", n, 17);
    chk("tmo_err", err, 1);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_out_valid", out_valid, 0);
    chk("tmo_blk_count", blk_count, bcnt);
    @(posedge Clk); #1 core_dead = 1'b0;
    // The chain was untouched, and err stays set across later good blocks
    send(d, 1'b1, 1'b0, 1);
    drain();
    chk("tmo_err_sticky", err, 1);

    // Reset while waiting for busy to fall
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 0);
    n = 0;
    while (!core_busy && n < 50) begin @(negedge Clk); n++; end
    chk("busy_wait", n < 50, 1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_core_start", core_start, 0);
    chk("mrst_core_block", core_block, 0);
    chk("mrst_err", err, 0);
    chk("mrst_blk_count", blk_count, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    chain_m = '0; bcnt = '0; key = '0;
    send('0, 1'b0, 1'b0, 1);
    drain();
    chk("mrst_after_count", blk_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/twofish_mode_ctrl.md
Name: twofish_mode_ctrl

Overview:
Streaming block-cipher mode controller that wraps the existing Twofish datapath core (Start/EnDe/block/key -> o/busy).
Accepts 128-bit blocks on a valid/ready stream and applies ECB or CBC, encrypting or decrypting each block.
Sequences the core one block at a time, supervises it with a timeout, and buffers results in an output FIFO.
Sits between the host/bus interface and the datapath core, replacing direct Start/busy poking.

Parameters:
BLOCK_W, 128, cipher block width; also the key width passed to the core
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
TIMEOUT, 1024, maximum cycles allowed per core operation before it is aborted
CNT_W, 16, width of the completed-block counter

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
key  in  BLOCK_W  cipher key, held stable by host while not idle
mode_cbc  in  1  0=ECB, 1=CBC; sampled on block accept
EnDe  in  1  0=encrypt, 1=decrypt; sampled on block accept
iv  in  BLOCK_W  initialisation vector
iv_load  in  1  one-cycle pulse: chain register <= iv
in_data  in  BLOCK_W  input block
in_valid  in  1  input handshake
in_ready  out  1  input handshake
out_data  out  BLOCK_W  result block (FIFO head)
out_valid  out  1  output handshake
out_ready  in  1  output handshake
core_block  out  BLOCK_W  to core block
core_key  out  BLOCK_W  to core key
core_start  out  1  to core Start, one-cycle pulse
core_ende  out  1  to core EnDe
core_o  in  BLOCK_W  from core o
core_busy  in  1  from core busy
err  out  1  sticky timeout flag
blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W

Behaviour:
- Reset (async): state IDLE; chain, FIFO, blk_count, err cleared; in_ready, out_valid, core_start = 0; core_block = 0.
- FSM: IDLE -> START -> WAIT_HI -> WAIT_LO -> PUSH -> IDLE.
- in_ready = (state==IDLE) && !iv_load && (fifo_count < FIFO_DEPTH). Accept on in_valid&&in_ready: latch in_data, mode_cbc, EnDe; go to START.
- Core input: ECB = in_data; CBC encrypt = in_data ^ chain; CBC decrypt = in_data. core_block/core_ende are registered and held from START until the core completes.
- START: core_start=1 for exactly one cycle -> WAIT_HI.
- WAIT_HI: wait for core_busy=1 -> WAIT_LO. WAIT_LO: wait for core_busy=0, then capture core_o -> PUSH.
- Result: ECB = core_o; CBC encrypt = core_o, and chain <= core_o; CBC decrypt = core_o ^ chain, and chain <= latched in_data. ECB leaves chain unchanged.
- PUSH: write the result into the FIFO, blk_count += 1 -> IDLE. A FIFO slot is guaranteed free because in_ready required space and only pops occur in between.
- Timeout: a cycle counter resets on START and counts through WAIT_HI and WAIT_LO. When it reaches TIMEOUT: err <= 1 (sticky until Reset), block dropped, chain unchanged, no push, -> IDLE.
- iv_load: honoured only in IDLE, takes priority over input accept in that cycle; ignored in other states.
- FIFO: out_valid = !empty; pop on out_valid&&out_ready. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- core_key = key (combinational pass-through).
- Mode or EnDe changes between blocks are legal; chain is not cleared on a mode change.
- Reset mid-operation: all state is lost immediately; the core's own reset is the host's responsibility.

Decomposition:
- Package twofish_pkg: BLOCK_W constant; state enum; mode constants MODE_ECB/MODE_CBC.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). Instantiated once for the output FIFO.

Test Plan:
- ECB encrypt, key=0, in_data=0 with the real datapath core -> out_data=9F589F5CF6122C32B6BFEC2F2AE8C35A, blk_count=1, err=0.
- CBC encrypt, key=0, iv_load with iv=0, two blocks of 0 -> 9F589F5CF6122C32B6BFEC2F2AE8C35A then D491DB16E7B1C39E86CB086B789F5419.
- CBC decrypt of those two ciphertexts with iv=0 -> 0, 0; chain ends at D491DB16E7B1C39E86CB086B789F5419.
- Hold out_ready=0 and stream 6 blocks, FIFO_DEPTH=4 -> in_ready drops after 4 accepted, no loss. Release out_ready -> remaining blocks flow, order preserved.
- Stub core that never raises busy, TIMEOUT=16 -> err=1 seventeen cycles after core_start, FSM back in IDLE, no output, blk_count unchanged.
- Assert Reset in WAIT_LO -> outputs immediately return to reset values; next ECB block 0 returns 9F589F5CF6122C32B6BFEC2F2AE8C35A.
